// File: rtl/axis_broadcaster.sv
// AXI4-Stream 1-to-2 broadcaster: every accepted beat is presented on both output lanes.
// Optional input skid buffer enabled by defining AXIS_BCAST_SKID_EN.
//
// Per-channel state:
//   state    | meaning
//   ST_IDLE  | channel has no beat waiting (m_axis_tvalid[i]=0)
//   ST_PEND  | channel holds the current beat until its consumer handshakes
module axis_broadcaster #(
  parameter int PAR_WDATA_BYTE = 2
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic [8*PAR_WDATA_BYTE-1:0]          s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  output logic [1:0][8*PAR_WDATA_BYTE-1:0]     m_axis_tdata,
  output logic [1:0]                           m_axis_tvalid,
  input  logic [1:0]                           m_axis_tready
);

  localparam int W = 8 * PAR_WDATA_BYTE;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } ch_state_t;

  ch_state_t      state_q [2];
  ch_state_t      state_d [2];
  logic [W-1:0]   data_q;
  logic [W-1:0]   data_d;
  logic           slot_free;
  logic           load;
  logic [W-1:0]   load_data;

  // Output stage can take a new beat only when no channel would be overwritten.
  always_comb begin
    slot_free = &(~m_axis_tvalid | m_axis_tready);
  end

`ifdef AXIS_BCAST_SKID_EN
  logic           skid_valid_q;
  logic           skid_valid_d;
  logic [W-1:0]   skid_data_q;
  logic [W-1:0]   skid_data_d;
  logic           s_ready_q;
  logic           accept;

  // Skid content always drains first so beat order is preserved.
  always_comb begin
    accept       = s_axis_tvalid && s_ready_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    load         = 1'b0;
    load_data    = s_axis_tdata;
    if (skid_valid_q) begin
      if (slot_free) begin
        load         = 1'b1;
        load_data    = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (slot_free) begin
        load = 1'b1;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = s_axis_tdata;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      s_ready_q    <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      s_ready_q    <= !skid_valid_d;
    end
  end

  assign s_axis_tready = s_ready_q;
`else
  always_comb begin
    load      = s_axis_tvalid && slot_free;
    load_data = s_axis_tdata;
  end

  assign s_axis_tready = slot_free;
`endif

  // A load re-arms both channels and wins over a same-cycle drain.
  always_comb begin
    data_d     = data_q;
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    if (load) begin
      data_d     = load_data;
      state_d[0] = ST_PEND;
      state_d[1] = ST_PEND;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (state_q[i] == ST_PEND && m_axis_tready[i]) begin
          state_d[i] = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q[0] <= ST_IDLE;
      state_q[1] <= ST_IDLE;
      data_q     <= '0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      data_q     <= data_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      m_axis_tvalid[i] = (state_q[i] == ST_PEND);
      m_axis_tdata[i]  = data_q;
    end
  end

endmodule

// File: tb/tb_axis_broadcaster.sv
// Directed self-checking bench for axis_broadcaster (PAR_WDATA_BYTE=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_axis_broadcaster;

  localparam int W = 16;

  logic              aclk = 1'b0;
  logic              areset;
  logic [W-1:0]      s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic [1:0][W-1:0] m_tdata;
  logic [1:0]        m_tvalid;
  logic [1:0]        m_tready;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  axis_broadcaster #(.PAR_WDATA_BYTE(2)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  task automatic test_reset;
    areset   = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 16'hBEEF;
    m_tready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      total++;
      if (m_tvalid !== 2'b00) begin
        bad++;
        $display("FAIL reset_tvalid cyc=%0d got=%b want=00", i, m_tvalid);
      end
      total++;
      if (m_tdata[0] !== 16'h0000 || m_tdata[1] !== 16'h0000) begin
        bad++;
        $display("FAIL reset_tdata cyc=%0d got=%h/%h want=0000", i, m_tdata[0], m_tdata[1]);
      end
    end
    areset   = 1'b0;
    s_tvalid = 1'b0;
    @(negedge aclk);
    total++;
    if (m_tvalid !== 2'b00) begin
      bad++;
      $display("FAIL reset_no_take got=%b want=00", m_tvalid);
    end
    total++;
    if (s_tready !== 1'b1) begin
      bad++;
      $display("FAIL reset_tready_after got=%b want=1", s_tready);
    end
  endtask

  task automatic test_stream;
    m_tready = 2'b11;
    for (int k = 0; k <= 16; k++) begin
      @(negedge aclk);
      if (k > 0) begin
        total++;
        if (m_tvalid !== 2'b11) begin
          bad++;
          $display("FAIL stream_tvalid k=%0d got=%b want=11", k, m_tvalid);
        end
        total++;
        if (m_tdata[0] !== 16'(k) || m_tdata[1] !== 16'(k)) begin
          bad++;
          $display("FAIL stream_data k=%0d got=%h/%h want=%h", k, m_tdata[0], m_tdata[1], 16'(k));
        end
      end
      if (k < 16) begin
        s_tdata  = 16'(k + 1);
        s_tvalid = 1'b1;
        #1;
        total++;
        if (s_tready !== 1'b1) begin
          bad++;
          $display("FAIL stream_tready k=%0d got=%b want=1", k, s_tready);
        end
      end else begin
        s_tvalid = 1'b0;
      end
    end
    @(negedge aclk);
    total++;
    if (m_tvalid !== 2'b00) begin
      bad++;
      $display("FAIL stream_drain got=%b want=00", m_tvalid);
    end
  endtask

  task automatic test_skewed_stall;
    logic [1:0] exp_v [6];
    logic [W-1:0] exp_d1 [6];
    exp_v  = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00};
    exp_d1 = '{16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'h5A5A, 16'h5A5A};
    @(negedge aclk);
    s_tdata  = 16'hA5A5;
    s_tvalid = 1'b1;
    m_tready = 2'b01;
    for (int n = 1; n <= 6; n++) begin
      @(negedge aclk);
      total++;
      if (m_tvalid !== exp_v[n-1]) begin
        bad++;
        $display("FAIL skew_tvalid n=%0d got=%b want=%b", n, m_tvalid, exp_v[n-1]);
      end
      if (n <= 5) begin
        total++;
        if (m_tdata[1] !== exp_d1[n-1]) begin
          bad++;
          $display("FAIL skew_data n=%0d got=%h want=%h", n, m_tdata[1], exp_d1[n-1]);
        end
      end
      if (n == 1) s_tdata = 16'h5A5A;
      if (n == 4) m_tready = 2'b11;
      if (n == 5) s_tvalid = 1'b0;
`ifndef AXIS_BCAST_SKID_EN
      #1;
      if (n <= 4) begin
        total++;
        if (s_tready !== (n == 4)) begin
          bad++;
          $display("FAIL skew_tready n=%0d got=%b want=%b", n, s_tready, (n == 4));
        end
      end
`endif
    end
  endtask

  task automatic test_drain_load;
    @(negedge aclk);
    s_tdata  = 16'h1111;
    s_tvalid = 1'b1;
    m_tready = 2'b00;
    @(negedge aclk);
    s_tvalid = 1'b0;
    @(negedge aclk);
    total++;
    if (m_tvalid !== 2'b11 || m_tdata[0] !== 16'h1111) begin
      bad++;
      $display("FAIL dl_hold got=%b/%h want=11/1111", m_tvalid, m_tdata[0]);
    end
    m_tready = 2'b11;
    s_tdata  = 16'h2222;
    s_tvalid = 1'b1;
    #1;
    total++;
    if (s_tready !== 1'b1) begin
      bad++;
      $display("FAIL dl_tready got=%b want=1", s_tready);
    end
    @(negedge aclk);
    s_tvalid = 1'b0;
    total++;
    if (m_tvalid !== 2'b11) begin
      bad++;
      $display("FAIL dl_tvalid got=%b want=11", m_tvalid);
    end
    total++;
    if (m_tdata[0] !== 16'h2222 || m_tdata[1] !== 16'h2222) begin
      bad++;
      $display("FAIL dl_data got=%h/%h want=2222", m_tdata[0], m_tdata[1]);
    end
    @(negedge aclk);
    total++;
    if (m_tvalid !== 2'b00) begin
      bad++;
      $display("FAIL dl_drain got=%b want=00", m_tvalid);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge aclk);
    s_tdata  = 16'h1234;
    s_tvalid = 1'b1;
    m_tready = 2'b01;
    @(negedge aclk);
    s_tvalid = 1'b0;
    @(negedge aclk);
    total++;
    if (m_tvalid !== 2'b10 || m_tdata[1] !== 16'h1234) begin
      bad++;
      $display("FAIL rmid_pend got=%b/%h want=10/1234", m_tvalid, m_tdata[1]);
    end
    areset   = 1'b1;
    m_tready = 2'b00;
    @(negedge aclk);
    areset   = 1'b0;
    m_tready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (m_tvalid !== 2'b00 || m_tdata[1] !== 16'h0000) begin
        bad++;
        $display("FAIL rmid_after cyc=%0d got=%b/%h want=00/0000", i, m_tvalid, m_tdata[1]);
      end
      @(negedge aclk);
    end
  endtask

`ifdef AXIS_BCAST_SKID_EN
  task automatic test_skid;
    logic [W-1:0] din [7];
    logic [W-1:0] dout [7];
    logic         rdy_exp [7];
    int           low_cnt;
    din     = '{16'h0100, 16'h0101, 16'h0102, 16'h0102, 16'h0103, 16'h0104, 16'h0105};
    dout    = '{16'h0100, 16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105};
    rdy_exp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    low_cnt = 0;
    for (int c = 0; c <= 7; c++) begin
      @(negedge aclk);
      if (c > 0) begin
        total++;
        if (m_tvalid !== 2'b11 || m_tdata[0] !== dout[c-1] || m_tdata[1] !== dout[c-1]) begin
          bad++;
          $display("FAIL skid_out c=%0d got=%b/%h/%h want=11/%h", c, m_tvalid, m_tdata[0], m_tdata[1], dout[c-1]);
        end
      end
      if (c < 7) begin
        s_tdata  = din[c];
        s_tvalid = 1'b1;
        m_tready = (c == 1) ? 2'b00 : 2'b11;
        #1;
        if (s_tready === 1'b0) low_cnt++;
        total++;
        if (s_tready !== rdy_exp[c]) begin
          bad++;
          $display("FAIL skid_tready c=%0d got=%b want=%b", c, s_tready, rdy_exp[c]);
        end
      end else begin
        s_tvalid = 1'b0;
      end
    end
    @(negedge aclk);
    total++;
    if (m_tvalid !== 2'b00) begin
      bad++;
      $display("FAIL skid_drain got=%b want=00", m_tvalid);
    end
    total++;
    if (low_cnt != 1) begin
      bad++;
      $display("FAIL skid_low_cycles got=%0d want=1", low_cnt);
    end
  endtask
`endif

  initial begin
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 2'b00;
    test_reset();
    test_stream();
    test_skewed_stall();
    test_drain_load();
    test_reset_mid();
`ifdef AXIS_BCAST_SKID_EN
    test_skid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
